// File: rtl/pdm_pkg.sv
// Shared types and constants for the stereo PDM modulator.
package pdm_pkg;
    localparam int SMPL_W      = 16;
    localparam int WINDOW_DFLT = 1153;
    localparam int NUM_LANES   = 2;

    localparam logic [SMPL_W-1:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [SMPL_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic [SMPL_W-1:0] smpl_t;

    function automatic smpl_t lfsr_next(smpl_t s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction
endpackage

// File: rtl/pdm_modulator_if.sv
// Sample-pair handshake between the audio source and the PDM modulator.
interface pdm_modulator_if;
    import pdm_pkg::*;

    smpl_t lft_smpl;
    smpl_t rght_smpl;
    logic  smpl_vld;
    logic  smpl_rdy;

    modport master (output lft_smpl, output rght_smpl, output smpl_vld, input smpl_rdy);
    modport slave  (input lft_smpl, input rght_smpl, input smpl_vld, output smpl_rdy);
endinterface

// File: rtl/pdm_sd_chan.sv
// One first-order sigma-delta channel: the carry out of the accumulator is the PDM bit.
module pdm_sd_chan
    import pdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  smpl_t operand,
    output logic  pdm
);
    smpl_t             acc;
    logic [SMPL_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, operand};

    // Accumulator is never cleared on frame boundaries so the error carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pdm <= 1'b0;
        end else begin
            acc <= sum[SMPL_W-1:0];
            pdm <= sum[SMPL_W];
        end
    end
endmodule

// File: rtl/pdm_modulator.sv
// Stereo PDM modulator with frame-based sample double buffering.
// Optional dither LFSR on the operand LSB enabled by macro PDM_DITHER_EN.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int WINDOW = WINDOW_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    pdm_modulator_if.slave  smpl,
    input  logic            clr_underflow,
    output logic            lft_PDM,
    output logic            rght_PDM,
    output logic            frame_strt,
    output logic            underflow
);
    localparam int              CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0]                 cnt;
    logic                             wrap;
    logic                             hold_full;
    logic                             accept;
    logic [NUM_LANES-1:0][SMPL_W-1:0] hold;
    logic [NUM_LANES-1:0][SMPL_W-1:0] active;
    logic [NUM_LANES-1:0][SMPL_W-1:0] operand;
    logic [NUM_LANES-1:0]             pdm;

    assign wrap          = (cnt == LAST);
    assign smpl.smpl_rdy = !hold_full;
    assign accept        = smpl.smpl_vld && !hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + CNT_W'(1);
    end

    // Lane 0 is left, lane 1 is right. Hold is full at the boundary, so no accept can collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            active    <= '0;
            hold_full <= 1'b0;
        end else if (wrap && hold_full) begin
            active    <= hold;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= {smpl.rght_smpl, smpl.lft_smpl};
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_strt <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            frame_strt <= wrap;
            if (wrap && !hold_full) underflow <= 1'b1;
            else if (clr_underflow) underflow <= 1'b0;
        end
    end

`ifdef PDM_DITHER_EN
    smpl_t lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    always_comb begin
        operand = '0;
        for (int i = 0; i < NUM_LANES; i++)
            operand[i] = {active[i][SMPL_W-1:1], lfsr[0]};
    end
`else
    assign operand = active;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
        pdm_sd_chan u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .operand (operand[i]),
            .pdm     (pdm[i])
        );
    end

    assign lft_PDM  = pdm[0];
    assign rght_PDM = pdm[1];
endmodule

// File: tb/tb_pdm_modulator.sv
// Directed self-checking bench for pdm_modulator (dither disabled, WINDOW=1153).
module tb_pdm_modulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_underflow = 1'b0;
    logic lft_PDM, rght_PDM, frame_strt, underflow;

    int checks = 0;
    int failures = 0;

    pdm_modulator_if smpl_if ();

    pdm_modulator #(.WINDOW(1153)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .smpl          (smpl_if.slave),
        .clr_underflow (clr_underflow),
        .lft_PDM       (lft_PDM),
        .rght_PDM      (rght_PDM),
        .frame_strt    (frame_strt),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with the counter at 0.
    task automatic do_reset;
        rst_n = 1'b0;
        clr_underflow = 1'b0;
        smpl_if.smpl_vld = 1'b0;
        smpl_if.lft_smpl = 16'h0000;
        smpl_if.rght_smpl = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 2000) begin
            @(negedge clk);
            n++;
            if (frame_strt) ok = 1'b1;
        end
    endtask

    task automatic count_ones(output int l, output int r);
        l = 0;
        r = 0;
        repeat (1153) begin
            @(negedge clk);
            l += int'(lft_PDM);
            r += int'(rght_PDM);
        end
    endtask

    task automatic test_reset;
        int l;
        l = 0;
        rst_n = 1'b0;
        smpl_if.smpl_vld = 1'b0;
        clr_underflow = 1'b0;
        step(2);
        checks++;
        if ({lft_PDM, rght_PDM, frame_strt, underflow, smpl_if.smpl_rdy} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00001",
                     {lft_PDM, rght_PDM, frame_strt, underflow, smpl_if.smpl_rdy});
        end
        rst_n = 1'b1;
        repeat (1152) begin
            @(negedge clk);
            l += int'(lft_PDM) + int'(rght_PDM) + int'(frame_strt) + int'(underflow);
        end
        checks++;
        if (l !== 0) begin
            failures++;
            $display("FAIL reset_first_frame_quiet got=%0d want=0", l);
        end
        step(1);
        checks++;
        if ({frame_strt, underflow, smpl_if.smpl_rdy} !== 3'b111) begin
            failures++;
            $display("FAIL reset_first_wrap fs/uf/rdy got=%b want=111",
                     {frame_strt, underflow, smpl_if.smpl_rdy});
        end
        step(1);
        checks++;
        if ({frame_strt, underflow} !== 2'b01) begin
            failures++;
            $display("FAIL reset_pulse_end fs/uf got=%b want=01", {frame_strt, underflow});
        end
    endtask

    task automatic test_frame_ones(input logic [15:0] ls, input logic [15:0] rs,
                                   input int lmin, input int lmax,
                                   input int rmin, input int rmax, input string name);
        int n, l, r;
        bit ok;
        do_reset();
        smpl_if.lft_smpl = ls;
        smpl_if.rght_smpl = rs;
        smpl_if.smpl_vld = 1'b1;
        wait_fs(n, ok);
        checks++;
        if (!ok || n != 1153) begin
            failures++;
            $display("FAIL %s first_frame_strt got=%0d ok=%0d want=1153", name, n, ok);
        end
        for (int f = 0; f < 2; f++) begin
            count_ones(l, r);
            checks++;
            if (l < lmin || l > lmax || r < rmin || r > rmax || underflow !== 1'b0) begin
                failures++;
                $display("FAIL %s frame%0d ones l=%0d r=%0d uf=%b want l=%0d..%0d r=%0d..%0d uf=0",
                         name, f, l, r, underflow, lmin, lmax, rmin, rmax);
            end
        end
        smpl_if.smpl_vld = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n, l, r;
        bit ok;
        do_reset();
        smpl_if.lft_smpl = 16'h0000;
        smpl_if.rght_smpl = 16'h0000;
        smpl_if.smpl_vld = 1'b1;
        checks++;
        if (smpl_if.smpl_rdy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_rdy got=%b want=1", smpl_if.smpl_rdy);
        end
        step(1);
        smpl_if.lft_smpl = 16'hFFFF;
        smpl_if.rght_smpl = 16'hFFFF;
        checks++;
        if (smpl_if.smpl_rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_rdy got=%b want=0", smpl_if.smpl_rdy);
        end
        n = 0;
        while (smpl_if.smpl_rdy !== 1'b1 && n < 2000) begin
            step(1);
            n++;
        end
        checks++;
        if (n != 1152 || frame_strt !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall_len got=%0d fs=%b want=1152 fs=1", n, frame_strt);
        end
        step(1);
        smpl_if.smpl_vld = 1'b0;
        checks++;
        if (smpl_if.smpl_rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept rdy got=%b want=0", smpl_if.smpl_rdy);
        end
        wait_fs(n, ok);
        checks++;
        if (!ok || n != 1152 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_load n=%0d uf=%b want n=1152 uf=0", n, underflow);
        end
        count_ones(l, r);
        checks++;
        if (l < 1152 || r < 1152 || frame_strt !== 1'b1 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_used l=%0d r=%0d fs=%b uf=%b want >=1152 fs=1 uf=1",
                     l, r, frame_strt, underflow);
        end
    endtask

    task automatic test_late_accept;
        int l, r;
        do_reset();
        step(1152);
        smpl_if.lft_smpl = 16'hFFFF;
        smpl_if.rght_smpl = 16'hFFFF;
        smpl_if.smpl_vld = 1'b1;
        checks++;
        if (smpl_if.smpl_rdy !== 1'b1) begin
            failures++;
            $display("FAIL late_rdy got=%b want=1", smpl_if.smpl_rdy);
        end
        step(1);
        smpl_if.smpl_vld = 1'b0;
        checks++;
        if ({frame_strt, underflow, smpl_if.smpl_rdy} !== 3'b110) begin
            failures++;
            $display("FAIL late_boundary fs/uf/rdy got=%b want=110",
                     {frame_strt, underflow, smpl_if.smpl_rdy});
        end
        count_ones(l, r);
        checks++;
        if (l != 0 || r != 0 || smpl_if.smpl_rdy !== 1'b1) begin
            failures++;
            $display("FAIL late_old_active l=%0d r=%0d rdy=%b want 0 0 1", l, r, smpl_if.smpl_rdy);
        end
        count_ones(l, r);
        checks++;
        if (l < 1152 || r < 1152) begin
            failures++;
            $display("FAIL late_new_active l=%0d r=%0d want>=1152", l, r);
        end
    endtask

    task automatic test_underflow_clr;
        do_reset();
        step(1153);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_set got=%b want=1", underflow);
        end
        step(10);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL uf_clear got=%b want=0", underflow);
        end
        step(1141);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        checks++;
        if ({frame_strt, underflow} !== 2'b11) begin
            failures++;
            $display("FAIL uf_set_beats_clr fs/uf got=%b want=11", {frame_strt, underflow});
        end
    endtask

    task automatic test_mid_reset;
        int n;
        bit ok;
        do_reset();
        smpl_if.lft_smpl = 16'hFFFF;
        smpl_if.rght_smpl = 16'hFFFF;
        smpl_if.smpl_vld = 1'b1;
        wait_fs(n, ok);
        step(500);
        checks++;
        if ({lft_PDM, rght_PDM, smpl_if.smpl_rdy} !== 3'b110) begin
            failures++;
            $display("FAIL midrst_before got=%b want=110", {lft_PDM, rght_PDM, smpl_if.smpl_rdy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lft_PDM, rght_PDM, frame_strt, underflow, smpl_if.smpl_rdy} !== 5'b00001) begin
            failures++;
            $display("FAIL midrst_async got=%b want=00001",
                     {lft_PDM, rght_PDM, frame_strt, underflow, smpl_if.smpl_rdy});
        end
        smpl_if.smpl_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(n, ok);
        checks++;
        if (!ok || n != 1153 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart n=%0d ok=%0d uf=%b want n=1153 uf=1", n, ok, underflow);
        end
    endtask

    initial begin
        test_reset();
        test_frame_ones(16'h8000, 16'h4000, 576, 577, 288, 289, "half_quarter");
        test_frame_ones(16'h0000, 16'hFFFF, 0, 0, 1152, 1153, "zero_full");
        test_back_to_back();
        test_late_accept();
        test_underflow_clr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 SHALL have parameter WINDOW, default 1153, meaning clocks per frame; the frame counter runs 0..WINDOW-1.
REQ-002 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port lft_smpl  input  16  unsigned left sample; ones-density = value/65536.
REQ-005 SHALL have port rght_smpl  input  16  unsigned right sample; same scaling.
REQ-006 SHALL have port smpl_vld  input  1  sample pair valid.
REQ-007 SHALL have port smpl_rdy  output  1  hold register empty, pair can be accepted.
REQ-008 SHALL have port clr_underflow  input  1  clears the sticky underflow flag.
REQ-009 SHALL have port lft_PDM  output  1  left PDM bitstream, registered.
REQ-010 SHALL have port rght_PDM  output  1  right PDM bitstream, registered.
REQ-011 SHALL have port frame_strt  output  1  one-cycle pulse in the counter==0 cycle after each wrap.
REQ-012 SHALL have port underflow  output  1  sticky flag: a frame started with no new sample.

Function
REQ-013 SHALL increment the frame counter every clock and wrap from WINDOW-1 to 0.
REQ-014 SHALL drive smpl_rdy = !hold_full combinationally; a pair is accepted when smpl_vld && smpl_rdy and stored in the hold register (hold_full <= 1).
REQ-015 SHALL, at counter==WINDOW-1 with hold_full=1, copy the hold register to the active register and clear hold_full in that cycle.
REQ-016 SHALL, at counter==WINDOW-1 with hold_full=0, keep the active register unchanged and set underflow; this applies even if a pair is accepted in that same cycle, and that pair is used at the following boundary.
REQ-017 SHALL set underflow with priority over clr_underflow when both occur in the same cycle.
REQ-018 SHALL register frame_strt as (counter==WINDOW-1).
REQ-019 SHALL give each channel a first-order sigma-delta: sum17 = {0,acc16} + {0,operand16}; PDM <= sum17[16]; acc16 <= sum17[15:0], every clock.
REQ-020 SHALL never clear the accumulators at frame boundaries; the error carries across frames.
REQ-021 SHALL use a new active sample from the first cycle of the next frame (counter==0); the first affected PDM bit appears one clock later.
REQ-022 SHALL hold PDM at constant 0 for operand 0x0000, and produce exactly one 0 per 65536 clocks for operand 0xFFFF.

Reset
REQ-023 SHALL, while rst_n is low, force counter=0, acc=0, active=0, hold_full=0, lft_PDM=rght_PDM=0, frame_strt=0 and underflow=0; smpl_rdy is therefore 1.
REQ-024 SHALL, when reset is asserted mid-frame, abandon the frame and restart at counter 0 with no pending sample.

Configuration
REQ-025 SHALL, with macro PDM_DITHER_EN defined, add a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 0xACE1) that advances every clock, with operand = {sample[15:1], lfsr[0]}; the LFSR resets to the seed.
REQ-026 SHALL, without PDM_DITHER_EN, contain no LFSR and use operand = sample, bit-exact.

Structure
REQ-027 SHALL put SMPL_W=16, WINDOW_DFLT=1153, LFSR_SEED, LFSR_TAPS and typedef smpl_t (logic[15:0]) in package pdm_pkg.
REQ-028 SHALL implement each channel as sub-module pdm_sd_chan (clk, rst_n, operand, pdm), instantiated twice; the counter, handshake and LFSR are in the top level.

Verification (dither off unless stated)
REQ-029 SHALL cover: reset with no samples -> lft/rght_PDM stay 0, smpl_rdy=1, underflow=1 the cycle after the first counter==1152.
REQ-030 SHALL cover: lft=0x8000, rght=0x4000, refilled every frame -> ones per full frame 576/577 left and 288/289 right; underflow stays 0.
REQ-031 SHALL cover: 0x0000 -> 0 ones per frame; 0xFFFF -> 1152 or 1153 ones per frame.
REQ-032 SHALL cover: two pairs offered back-to-back -> second stalls with smpl_rdy=0 until the cycle after counter==1152, then is accepted.
REQ-033 SHALL cover: underflow set, clr_underflow pulsed -> flag clears; clr_underflow coincident with a new underflow -> flag stays 1.
REQ-034 SHALL cover: rst_n low at counter==500 -> all outputs 0 immediately; after release frame_strt first pulses 1153 clocks later.
